// File: rtl/apb_pstwo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_pstwo_ctrl : APB-mapped PS2 gamepad serial engine with TX/RX byte buffers
// Revision 1.0
// ---------------------------------------------------------------------------
module apb_pstwo_ctrl #(
  parameter int CLK_DIV   = 50,
  parameter int BYTE_GAP  = 100,
  parameter int MAX_BYTES = 9,
  parameter int N_PADS    = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic [15:0]       PADDR,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [N_PADS-1:0] PS2_CS,
  output logic              PS2_CLK,
  output logic              PS2_DO,
  input  logic              PS2_DI,
  output logic              IRQ
);
  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);
  localparam logic [11:0] GAP_LAST = 12'(BYTE_GAP - 1);
  localparam logic [5:0]  MAXB     = 6'(MAX_BYTES);
  localparam logic [2:0]  NPADS    = 3'(N_PADS);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_HOLD} state_t;

  state_t              state_q;
  logic [11:0]         cnt_q;
  logic [2:0]          bit_q;
  logic                phase_q;
  logic [3:0]          idx_q, frame_nb_q;
  logic [7:0]          rx_sh_q;
  logic [N_PADS-1:0]   cs_q;
  logic                clk_q, do_q;
  logic                di_meta_q, di_sync_q;
  logic [1:0]          pad_sel_q;
  logic [3:0]          nbytes_q;
  logic                irq_en_q, done_q, err_q, irq_q;
  logic [7:0]          txbuf_q [MAX_BYTES];
  logic [7:0]          rxbuf_q [MAX_BYTES];

  logic [11:0] w_addr;
  logic [5:0]  w_buf_idx;
  logic        w_wr, w_busy, w_is_ctrl, w_is_stat, w_buf_ok, w_is_tx, w_is_rx;
  logic        w_ctrl_wr, w_go, w_valid, w_start, w_err_set, w_done_set;
  logic [7:0]  w_tx_cur;
  logic        unused_ok;

  assign w_addr    = PADDR[11:0];
  assign w_buf_idx = w_addr[7:2];
  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_busy    = (state_q != S_IDLE);
  assign w_is_ctrl = (w_addr == 12'h000);
  assign w_is_stat = (w_addr == 12'h004);
  assign w_buf_ok  = (w_addr[1:0] == 2'b00) && (w_buf_idx < MAXB);
  assign w_is_tx   = (w_addr[11:8] == 4'h1) && w_buf_ok;
  assign w_is_rx   = (w_addr[11:8] == 4'h2) && w_buf_ok;

  assign PREADY  = 1'b1;
  assign PSLVERR = w_wr & w_busy & ((w_is_ctrl & PWDATA[0]) | w_is_tx);

  assign w_ctrl_wr  = w_wr & w_is_ctrl & ~PSLVERR;
  assign w_go       = w_ctrl_wr & PWDATA[0];
  assign w_valid    = (PWDATA[11:8] != 4'd0) && ({2'b00, PWDATA[11:8]} <= MAXB) &&
                      ({1'b0, PWDATA[5:4]} < NPADS);
  assign w_start    = w_go & w_valid;
  assign w_err_set  = w_go & ~w_valid;
  assign w_done_set = (state_q == S_HOLD) && (cnt_q == DIV_LAST);

  assign unused_ok = ^{PADDR[15:12], PWDATA[31:17], PWDATA[15:12]};

  always_comb begin
    w_tx_cur = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++)
      if (idx_q == 4'(i)) w_tx_cur = txbuf_q[i];
  end

  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      if (w_is_ctrl) begin
        PRDATA[16]   = irq_en_q;
        PRDATA[11:8] = nbytes_q;
        PRDATA[5:4]  = pad_sel_q;
      end
      if (w_is_stat) PRDATA[2:0] = {err_q, done_q, w_busy};
      for (int i = 0; i < MAX_BYTES; i++) begin
        if (w_is_tx && w_buf_idx == 6'(i)) PRDATA[7:0] = txbuf_q[i];
        if (w_is_rx && w_buf_idx == 6'(i)) PRDATA[7:0] = rxbuf_q[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      di_meta_q <= 1'b0;
      di_sync_q <= 1'b0;
    end else begin
      di_meta_q <= PS2_DI;
      di_sync_q <= di_meta_q;
    end
  end

  // Register file; a DONE set in the same cycle as its W1C takes priority.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pad_sel_q <= 2'd0;
      nbytes_q  <= 4'd0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) txbuf_q[i] <= 8'h00;
    end else begin
      if (w_ctrl_wr) begin
        pad_sel_q <= PWDATA[5:4];
        nbytes_q  <= PWDATA[11:8];
        irq_en_q  <= PWDATA[16];
      end
      if (w_done_set)                           done_q <= 1'b1;
      else if (w_wr && w_is_stat && PWDATA[1])  done_q <= 1'b0;
      if (w_err_set)                            err_q  <= 1'b1;
      else if (w_wr && w_is_stat && PWDATA[2])  err_q  <= 1'b0;
      irq_q <= done_q & irq_en_q;
      for (int i = 0; i < MAX_BYTES; i++)
        if (w_wr && !PSLVERR && w_is_tx && w_buf_idx == 6'(i)) txbuf_q[i] <= PWDATA[7:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 12'd0;
      bit_q      <= 3'd0;
      phase_q    <= 1'b0;
      idx_q      <= 4'd0;
      frame_nb_q <= 4'd0;
      rx_sh_q    <= 8'h00;
      cs_q       <= {N_PADS{1'b1}};
      clk_q      <= 1'b1;
      do_q       <= 1'b1;
      for (int i = 0; i < MAX_BYTES; i++) rxbuf_q[i] <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: if (w_start) begin
          state_q    <= S_SETUP;
          cnt_q      <= 12'd0;
          idx_q      <= 4'd0;
          frame_nb_q <= PWDATA[11:8];
          cs_q       <= {N_PADS{1'b1}} ^ (N_PADS'(1) << PWDATA[5:4]);
        end
        S_SETUP, S_GAP: begin
          if (cnt_q == ((state_q == S_SETUP) ? DIV_LAST : GAP_LAST)) begin
            state_q <= S_SHIFT;
            cnt_q   <= 12'd0;
            bit_q   <= 3'd0;
            phase_q <= 1'b0;
            clk_q   <= 1'b0;
            do_q    <= w_tx_cur[0];
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        S_SHIFT: begin
          // DI is captured during the first PCLK cycle of the CLK-high phase.
          if (phase_q && cnt_q == 12'd0) rx_sh_q <= {di_sync_q, rx_sh_q[7:1]};
          if (cnt_q != DIV_LAST) begin
            cnt_q <= cnt_q + 12'd1;
          end else begin
            cnt_q <= 12'd0;
            if (!phase_q) begin
              phase_q <= 1'b1;
              clk_q   <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (bit_q != 3'd7) begin
                bit_q <= bit_q + 3'd1;
                clk_q <= 1'b0;
                do_q  <= w_tx_cur[bit_q + 3'd1];
              end else begin
                for (int i = 0; i < MAX_BYTES; i++)
                  if (idx_q == 4'(i)) rxbuf_q[i] <= rx_sh_q;
                do_q <= 1'b1;
                if ((idx_q + 4'd1) == frame_nb_q) begin
                  state_q <= S_HOLD;
                end else begin
                  state_q <= S_GAP;
                  idx_q   <= idx_q + 4'd1;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == DIV_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= 12'd0;
            cs_q    <= {N_PADS{1'b1}};
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PS2_CS  = cs_q;
  assign PS2_CLK = clk_q;
  assign PS2_DO  = do_q;
  assign IRQ     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_pstwo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_pstwo_ctrl : directed bench for apb_pstwo_ctrl with a simple pad model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_apb_pstwo_ctrl;
  localparam int CLK_DIV   = 4;
  localparam int BYTE_GAP  = 8;
  localparam int MAX_BYTES = 9;
  localparam int N_PADS    = 2;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [15:0] PADDR = 16'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, PS2_CLK, PS2_DO, IRQ;
  logic [N_PADS-1:0] PS2_CS;
  logic        pad_di = 1'b1;

  int checks = 0, failures = 0;
  int cs0_low = 0, cs1_low = 0;
  int pad_bit = 0;
  logic do_log [1024];
  int do_n = 0;
  logic [7:0] resp [3] = '{8'hFF, 8'h41, 8'h5A};

  apb_pstwo_ctrl #(.CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP), .MAX_BYTES(MAX_BYTES), .N_PADS(N_PADS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PS2_CS(PS2_CS), .PS2_CLK(PS2_CLK), .PS2_DO(PS2_DO), .PS2_DI(pad_di), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (!PS2_CS[0]) cs0_low++;
    if (!PS2_CS[1]) cs1_low++;
  end

  // Pad 0 model: drives the next response bit on each falling PS2_CLK.
  always @(negedge PS2_CLK or negedge PS2_CS[0]) begin
    if (!PS2_CS[0] && PS2_CLK) begin
      pad_bit = 0;
      pad_di  = 1'b1;
    end else if (!PS2_CS[0]) begin
      pad_di  = resp[(pad_bit / 8) % 3][pad_bit % 8];
      pad_bit++;
    end
  end

  always @(posedge PS2_CLK) begin
    if (!PS2_CS[0] && do_n < 1024) begin
      do_log[do_n] = PS2_DO;
      do_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (PS2_CS != 2'b11 && g < 3000) begin
      @(negedge PCLK);
      g++;
    end
    check(tag, 32'(PS2_CS == 2'b11), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] d;
    logic [7:0]  b;
    int          b0, b1, db, n, g;
    logic [7:0]  exp_rx [3] = '{8'hFF, 8'h41, 8'h5A};

    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_cs", 32'(PS2_CS), 32'h3);
    check("rst_clk", 32'(PS2_CLK), 32'h1);
    check("rst_do", 32'(PS2_DO), 32'h1);
    check("rst_irq", 32'(IRQ), 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("pready", 32'(PREADY), 32'h1);
    apb_read(16'h004, d); check("rst_status", d, 32'h0);
    for (int i = 0; i < MAX_BYTES; i++) begin
      apb_read(16'(16'h200 + 4 * i), d); check($sformatf("rst_rx%0d", i), d, 32'h0);
    end

    // Poll frame: 01 42 00 out, FF 41 5A back.
    apb_write(16'h100, 32'h01, e); check("tx_wr_err", 32'(e), 32'h0);
    apb_write(16'h104, 32'h42, e);
    apb_write(16'h108, 32'h00, e);
    b0 = cs0_low; b1 = cs1_low; db = do_n;
    apb_write(16'h000, 32'h0001_0301, e);
    check("start_pslverr", 32'(e), 32'h0);
    check("start_cs_next", 32'(PS2_CS), 32'h2);
    wait_idle("poll_done_wait");
    check("poll_cs0_len", 32'(cs0_low - b0), 32'd216);
    check("poll_cs1_len", 32'(cs1_low - b1), 32'd0);
    for (int i = 0; i < 8; i++) b[i] = do_log[db + i];
    check("do_byte0", 32'(b), 32'h01);
    for (int i = 0; i < 8; i++) b[i] = do_log[db + 8 + i];
    check("do_byte1", 32'(b), 32'h42);
    apb_read(16'h004, d); check("poll_status", d, 32'h2);
    check("poll_irq", 32'(IRQ), 32'h1);
    for (int i = 0; i < 3; i++) begin
      apb_read(16'(16'h200 + 4 * i), d); check($sformatf("poll_rx%0d", i), d, 32'(exp_rx[i]));
    end
    apb_read(16'h20C, d); check("poll_rx3_untouched", d, 32'h0);
    apb_write(16'h004, 32'h2, e);
    @(posedge PCLK); #1;
    check("irq_cleared", 32'(IRQ), 32'h0);

    // Invalid starts.
    b0 = cs0_low; b1 = cs1_low;
    apb_write(16'h000, 32'h0000_0001, e);
    apb_read(16'h004, d); check("inv_nb0_status", d, 32'h4);
    apb_write(16'h004, 32'h4, e);
    apb_write(16'h000, 32'h0000_0A01, e);
    apb_read(16'h004, d); check("inv_nb10_status", d, 32'h4);
    apb_write(16'h004, 32'h4, e);
    apb_write(16'h000, 32'h0000_0321, e);
    apb_read(16'h004, d); check("inv_pad2_status", d, 32'h4);
    apb_read(16'h000, d); check("inv_pad2_ctrl", d, 32'h320);
    apb_write(16'h004, 32'h4, e);
    apb_read(16'h004, d); check("err_w1c", d, 32'h0);
    check("inv_cs_quiet", 32'((cs0_low - b0) + (cs1_low - b1)), 32'd0);

    // Largest frame on pad 1.
    b0 = cs0_low; b1 = cs1_low;
    apb_write(16'h000, 32'h0000_0911, e);
    wait_idle("max_done_wait");
    check("max_cs1_len", 32'(cs1_low - b1), 32'd648);
    check("max_cs0_len", 32'(cs0_low - b0), 32'd0);
    apb_write(16'h004, 32'h2, e);
    apb_write(16'h108, 32'h00, e);

    // Writes while busy are refused.
    apb_write(16'h000, 32'h0000_0301, e);
    apb_write(16'h104, 32'h55, e); check("busy_tx_pslverr", 32'(e), 32'h1);
    apb_write(16'h000, 32'h0001_0901, e); check("busy_ctrl_pslverr", 32'(e), 32'h1);
    apb_read(16'h000, d); check("busy_ctrl_kept", d, 32'h300);
    wait_idle("busy_done_wait");
    apb_read(16'h104, d); check("busy_tx1_kept", d, 32'h42);
    apb_read(16'h204, d); check("busy_rx1", d, 32'h41);
    apb_read(16'h004, d); check("busy_status", d, 32'h2);
    apb_write(16'h004, 32'h2, e);

    // W1C of DONE landing on the cycle DONE sets.
    apb_write(16'h000, 32'h0001_0301, e);
    n = 0; g = 0;
    while (n < 215 && g < 2000) begin
      @(negedge PCLK);
      g++;
      if (!PS2_CS[0]) n++;
    end
    check("race_align", 32'(n), 32'd215);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 16'h004; PWDATA = 32'h2;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("race_cs_high", 32'(PS2_CS), 32'h3);
    apb_read(16'h004, d); check("race_done_kept", d, 32'h2);
    check("race_irq_kept", 32'(IRQ), 32'h1);
    apb_write(16'h004, 32'h2, e);
    @(posedge PCLK); #1;
    check("race_irq_clr", 32'(IRQ), 32'h0);
    apb_read(16'h004, d); check("race_done_clr", d, 32'h0);

    // Reset during byte 1 of a 3-byte frame.
    apb_write(16'h000, 32'h0000_0301, e);
    repeat (100) @(negedge PCLK);
    check("mid_cs_low", 32'(PS2_CS), 32'h2);
    PRESETn = 1'b0;
    #1;
    check("mid_rst_cs", 32'(PS2_CS), 32'h3);
    check("mid_rst_clk", 32'(PS2_CLK), 32'h1);
    check("mid_rst_do", 32'(PS2_DO), 32'h1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    apb_read(16'h004, d); check("mid_status", d, 32'h0);
    for (int i = 0; i < MAX_BYTES; i++) begin
      apb_read(16'(16'h200 + 4 * i), d); check($sformatf("mid_rx%0d", i), d, 32'h0);
    end
    check("mid_irq", 32'(IRQ), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_pstwo_ctrl.md
# apb_pstwo_ctrl

APB peripheral that runs the PS2 gamepad serial protocol in hardware. It supersedes software bit-banging of CS/CLK/DO/DI: firmware loads a command frame, selects a pad and starts the transfer. The block then shifts up to MAX_BYTES bytes full-duplex, LSB-first, and captures the response into a read buffer. It sits on the APB bus at 0x40005000 with one chip select per attached controller and an optional completion interrupt.

## Interface
Parameters:
- CLK_DIV, 50: PCLK cycles per PS2_CLK half-period; legal 4..1023.
- BYTE_GAP, 100: PCLK cycles of idle PS2_CLK high between bytes; legal 1..4095.
- MAX_BYTES, 9: TX/RX buffer depth in bytes; legal 2..16.
- N_PADS, 2: number of controllers, one PS2_CS bit each; legal 1..4.

Ports:
- PCLK, input, 1: clock.
- PRESETn, input, 1: asynchronous active-low reset.
- PSEL, input, 1: device select.
- PADDR, input, 16: address; only [11:0] decoded.
- PENABLE, input, 1: APB access phase.
- PWRITE, input, 1: write control.
- PWDATA, input, 32: write data.
- PRDATA, output, 32: read data.
- PREADY, output, 1: constant 1.
- PSLVERR, output, 1: error response.
- PS2_CS, output, N_PADS: active-low chip selects.
- PS2_CLK, output, 1: serial clock, idle high.
- PS2_DO, output, 1: command data to pad, idle high.
- PS2_DI, input, 1: response data from pad, asynchronous.
- IRQ, output, 1: level interrupt.

## Operation
- Write strobe is PSEL & PENABLE & PWRITE.
- PRDATA is combinational from PADDR when PSEL & ~PWRITE, else 0.
- Unmapped reads return 0.
- Register map:
  - 0x000 CTRL RW: [0] START (write 1 = go, reads 0); [5:4] PAD_SEL; [11:8] NBYTES; [16] IRQ_EN.
  - 0x004 STATUS: [0] BUSY (RO); [1] DONE (W1C); [2] ERR (W1C).
  - 0x100+4*i TXBUF[i] RW, bits [7:0], for i < MAX_BYTES.
  - 0x200+4*i RXBUF[i] RO, bits [7:0], for i < MAX_BYTES.
- START is accepted only if NBYTES is 1..MAX_BYTES and PAD_SEL < N_PADS. Otherwise ERR sets and no transfer occurs; the other CTRL fields still update.
- PSLVERR=1 on a write to CTRL with START=1 or to any TXBUF while BUSY. That write is dropped entirely.
- PS2_DI passes through a 2-flop synchronizer. All sampling uses the synced value.
- FSM:
  - IDLE: all CS high, CLK high, DO high. Valid START -> SETUP.
  - SETUP: CS[PAD_SEL] low for CLK_DIV cycles -> SHIFT.
  - SHIFT: 8 bits, LSB first. Per bit: DO = bit, CLK low for CLK_DIV cycles, then CLK high for CLK_DIV cycles. The synced DI is sampled on the cycle CLK goes high. After bit 7, the assembled byte is written to RXBUF[idx].
  - After each byte: if more bytes remain -> GAP (CLK high, DO high, BYTE_GAP cycles) -> SHIFT; otherwise -> HOLD.
  - HOLD: CLK_DIV cycles with CS low -> IDLE. On exit, CS goes high, BUSY clears and DONE sets.
- IRQ = DONE & IRQ_EN, registered.
- RXBUF entries at index >= NBYTES are left unchanged.

## Timing
- Reset values:
  - PS2_CS all 1, PS2_CLK 1, PS2_DO 1, IRQ 0, PSLVERR 0, PRDATA 0.
  - All registers and buffers 0.
- START written in access cycle T: BUSY reads 1 and CS[PAD_SEL] is low from T+1.
- CS low time is exactly 2*CLK_DIV + NBYTES*16*CLK_DIV + (NBYTES-1)*BYTE_GAP PCLK cycles.
- DONE and IRQ (with IRQ_EN=1) are visible on the cycle after CS rises.
- A W1C to DONE in the same cycle that DONE sets: the set wins.
- A new START may be issued the cycle after BUSY clears.
- Counters are sized for maximum parameter values. No wrap is possible within a frame.
- PRESETn asserted mid-transfer returns the block to IDLE immediately: CS high, CLK high, all buffers 0, no DONE.
- DI sampling latency is 2 PCLK cycles behind the pin. The pad must hold DI stable for at least 3 PCLK cycles around each CLK rising edge.

## Test plan
All scenarios use CLK_DIV=4, BYTE_GAP=8, MAX_BYTES=9, N_PADS=2.
- Reset -> CS=2'b11, CLK=1, DO=1, STATUS=0, RXBUF[0..8]=0, IRQ=0.
- Poll frame:
  - Stimulus: TXBUF = 0x01, 0x42, 0x00; CTRL = START | NBYTES=3 | PAD_SEL=0 | IRQ_EN; pad model returns 0xFF, 0x41, 0x5A.
  - Response: RXBUF = FF, 41, 5A; DO of byte 0 is 1,0,0,0,0,0,0,0; CS[0] low for exactly 216 cycles; CS[1] stays high; DONE=1 and IRQ=1.
- Invalid starts: NBYTES=0, NBYTES=10 and PAD_SEL=2 -> each gives ERR=1, BUSY=0, no CS activity. W1C of 0x4 -> ERR=0.
- Write TXBUF[1]=0x55 while BUSY -> PSLVERR=1 in that access; TXBUF[1] unchanged; transfer completes normally.
- PRESETn low during byte 1 of a 3-byte frame -> CS/CLK/DO return to 1 immediately. After release, STATUS=0 and RXBUF all 0.
- W1C to DONE issued on the same cycle DONE sets -> DONE stays 1 and IRQ stays 1. A following W1C -> DONE=0 and IRQ=0 one cycle later.
